// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: RV32I size codes,
// FSM state encoding and the registered request payload.
package load_store_unit_pkg;

    localparam int unsigned LSU_ADDR_W = 17;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } lsu_state_e;

    // Request fields that must survive into the second half of a split access.
    typedef struct packed {
        logic        store;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [31:0] wdata;
    } lsu_req_t;

    // Byte mask of the access size, right-aligned; 0 for unknown codes.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        logic [3:0] mask;
        unique case (funct3)
            F3_B, F3_BU: mask = 4'b0001;
            F3_H, F3_HU: mask = 4'b0011;
            F3_W:        mask = 4'b1111;
            default:     mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
        logic ok;
        unique case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational datapath of the load/store unit: byte enables over a
// two-word window, store lane rotation and load extract/extend.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [7:0]  ext,
    output logic        legal,
    output logic [31:0] wdata_rot,
    output logic [31:0] load_data
);

    logic [31:0] low;

    assign legal = funct3_legal(store, funct3);
    assign ext   = {4'b0000, size_mask(funct3)} << off;

    // Store data is rotated so byte 0 lands on lane off; both halves share it.
    always_comb begin
        wdata_rot = wdata;
        unique case (off)
            2'd0: wdata_rot = wdata;
            2'd1: wdata_rot = {wdata[23:0], wdata[31:24]};
            2'd2: wdata_rot = {wdata[15:0], wdata[31:16]};
            2'd3: wdata_rot = {wdata[7:0],  wdata[31:8]};
            default: wdata_rot = wdata;
        endcase
    end

    assign low = 32'({word1, word0} >> {off, 3'b000});

    always_comb begin
        load_data = low;
        unique case (funct3)
            F3_B:    load_data = {{24{low[7]}}, low[7:0]};
            F3_BU:   load_data = {24'h000000, low[7:0]};
            F3_H:    load_data = {{16{low[15]}}, low[15:0]};
            F3_HU:   load_data = {16'h0000, low[15:0]};
            default: load_data = low;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues word accesses to data memory, splits accesses that
// cross a word boundary over two cycles, and returns registered responses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [31:0]       mem_w_data,
    input  logic [31:0]       mem_r_data,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata
);

    localparam logic [ADDR_W-1:0] LAST_WORD = {{(ADDR_W-2){1'b1}}, 2'b00};

    lsu_state_e        state;
    lsu_req_t          req_q;
    lsu_req_t          cur;
    logic [ADDR_W-1:0] w1_q;
    logic [31:0]       word0_q;

    logic              in_split;
    logic              accept;
    logic [ADDR_W-1:0] w0;
    logic [ADDR_W-1:0] w1;
    logic [7:0]        ext;
    logic              legal;
    logic              need_split;
    logic              req_err;
    logic [31:0]       wdata_rot;
    logic [31:0]       load_data;
    logic [31:0]       win_word0;
    logic [31:0]       win_word1;

    assign in_split  = (state == ST_SPLIT);
    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // In SPLIT the datapath runs from the captured request, otherwise from the live one.
    assign cur = in_split ? req_q
                          : '{store: req_store, funct3: req_funct3,
                              off: req_addr[1:0], wdata: req_wdata};

    assign w0 = {req_addr[ADDR_W-1:2], 2'b00};
    assign w1 = w0 + ADDR_W'(4);

    // Word0 is held so the second read can complete the two-word window.
    assign win_word0 = in_split ? word0_q : mem_r_data;
    assign win_word1 = in_split ? mem_r_data : 32'h0;

    load_store_unit_align u_align (
        .store     (cur.store),
        .funct3    (cur.funct3),
        .off       (cur.off),
        .wdata     (cur.wdata),
        .word0     (win_word0),
        .word1     (win_word1),
        .ext       (ext),
        .legal     (legal),
        .wdata_rot (wdata_rot),
        .load_data (load_data)
    );

    assign need_split = |ext[7:4];
    assign req_err    = (|req_addr[31:ADDR_W]) || !legal
                      || (need_split && (w0 == LAST_WORD));

    assign mem_r_addr = in_split ? w1_q : w0;
    assign mem_w_addr = mem_r_addr;
    assign mem_w_data = wdata_rot;

    always_comb begin
        mem_we = 4'b0000;
        if (rst) begin
            mem_we = 4'b0000;
        end else if (in_split) begin
            mem_we = req_q.store ? ext[7:4] : 4'b0000;
        end else if (accept && !req_err && req_store) begin
            mem_we = ext[3:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            w1_q       <= '0;
            word0_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (need_split) begin
                            state   <= ST_SPLIT;
                            req_q   <= cur;
                            w1_q    <= w1;
                            word0_q <= mem_r_data;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= req_store ? 32'h0 : load_data;
                        end
                    end
                end
                ST_SPLIT: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b1;
                    resp_rdata <= req_q.store ? 32'h0 : load_data;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
